// File: rtl/peripheral_ahb3_pkg.sv
// -----------------------------------------------------------------------------
// peripheral_ahb3_pkg
// Purpose : Shared AHB3-Lite encodings (HTRANS, HSIZE, HRESP) used by the
//           AHB-to-memory bridge and its byte-enable generator.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package peripheral_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HWORD   = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HSIZE_DWORD   = 3'b011;
    localparam logic [2:0] HSIZE_B128    = 3'b100;
    localparam logic [2:0] HSIZE_B256    = 3'b101;
    localparam logic [2:0] HSIZE_B512    = 3'b110;
    localparam logic [2:0] HSIZE_B1024   = 3'b111;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

endpackage

// File: rtl/pu_riscv_ahb3_be_gen.sv
// -----------------------------------------------------------------------------
// pu_riscv_ahb3_be_gen
// Purpose : Combinational byte-enable generator. Turns an AHB transfer size and
//           the low address bits into a byte-lane mask, and flags transfers
//           that are wider than the bus or not aligned to their own size.
// Ports   : i_hsize    - AHB HSIZE of the transfer
//           i_addr_lsb - address bits below the bus-word boundary
//           o_be       - byte enables, (2**HSIZE) ones shifted by i_addr_lsb
//           o_err      - oversize or misaligned transfer
// -----------------------------------------------------------------------------
module pu_riscv_ahb3_be_gen
    import peripheral_ahb3_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]                    i_hsize,
    input  logic [$clog2(XLEN/8)-1:0]     i_addr_lsb,
    output logic [XLEN/8-1:0]             o_be,
    output logic                          o_err
);

    localparam int BW = XLEN / 8;
    localparam int AW = $clog2(BW);

    int w_nbytes;
    int w_lsb;

    always_comb begin
        o_be     = '0;
        o_err    = 1'b0;
        w_lsb    = int'(i_addr_lsb);
        w_nbytes = 32'd1 << i_hsize;
        if (int'(i_hsize) > AW) begin
            o_err = 1'b1;
        end else begin
            // Natural alignment: the low HSIZE address bits must be zero.
            if ((w_lsb & (w_nbytes - 1)) != 0) begin
                o_err = 1'b1;
            end
            for (int i = 0; i < BW; i++) begin
                o_be[i] = (i >= w_lsb) && (i < w_lsb + w_nbytes);
            end
        end
    end

endmodule

// File: rtl/pu_riscv_ahb32mem.sv
// -----------------------------------------------------------------------------
// pu_riscv_ahb32mem
// Purpose : AHB3-Lite slave that turns each bus beat into one req/ack request
//           on a simple memory port. Wait states are inserted until the memory
//           acknowledges; oversize/misaligned transfers and memory errors get
//           the two-cycle AHB ERROR response.
// Ports   : HCLK/HRESETn           - clock, asynchronous active-low reset
//           HSEL..HREADY            - AHB address/data phase inputs
//           HRDATA/HREADYOUT/HRESP  - AHB slave response
//           mem_req_o..mem_lock_o   - memory request (held until mem_ack_i)
//           mem_q_i/ack_i/err_i     - memory response
// -----------------------------------------------------------------------------
module pu_riscv_ahb32mem
    import peripheral_ahb3_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PLEN = 64
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                HSEL,
    input  logic [PLEN-1:0]     HADDR,
    input  logic [XLEN-1:0]     HWDATA,
    output logic [XLEN-1:0]     HRDATA,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [2:0]          HBURST,
    input  logic [3:0]          HPROT,
    input  logic [1:0]          HTRANS,
    input  logic                HMASTLOCK,
    input  logic                HREADY,
    output logic                HREADYOUT,
    output logic                HRESP,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [PLEN-1:0]     mem_adr_o,
    output logic [XLEN/8-1:0]   mem_be_o,
    output logic [XLEN-1:0]     mem_d_o,
    output logic                mem_lock_o,
    input  logic [XLEN-1:0]     mem_q_i,
    input  logic                mem_ack_i,
    input  logic                mem_err_i
);

    localparam int BW = XLEN / 8;
    localparam int AW = $clog2(BW);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        ERR1,
        ERR2
    } state_t;

    state_t            r_state;
    logic              r_hreadyout;
    logic              r_hresp;
    logic [XLEN-1:0]   r_hrdata;
    logic              r_req;
    logic              r_we;
    logic [PLEN-1:0]   r_adr;
    logic [BW-1:0]     r_be;
    logic              r_lock;

    logic [BW-1:0]     w_be;
    logic              w_illegal;
    logic              w_sample;
    logic              w_unused;

    // Burst type, protection and the NONSEQ/SEQ distinction carry no meaning here:
    // every beat is an independent request with its own HADDR.
    assign w_unused = &{1'b0, HBURST, HPROT, HTRANS[0]};

    assign w_sample = HSEL & HREADY & HTRANS[1];

    pu_riscv_ahb3_be_gen #(
        .XLEN (XLEN)
    ) u_be_gen (
        .i_hsize    (HSIZE),
        .i_addr_lsb (HADDR[AW-1:0]),
        .o_be       (w_be),
        .o_err      (w_illegal)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
            r_hrdata    <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_be        <= '0;
            r_lock      <= 1'b0;
        end else begin
            case (r_state)
                // States with HREADYOUT=1 accept a new address phase.
                IDLE, RESP, ERR2: begin
                    if (w_sample) begin
                        r_lock <= HMASTLOCK;
                        if (w_illegal) begin
                            r_state     <= ERR1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= HRESP_ERROR;
                        end else begin
                            r_state     <= REQ;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= HRESP_OKAY;
                            r_req       <= 1'b1;
                            r_we        <= HWRITE;
                            r_adr       <= HADDR & ~PLEN'(BW - 1);
                            r_be        <= w_be;
                        end
                    end else begin
                        r_state     <= IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= HRESP_OKAY;
                    end
                end
                REQ: begin
                    if (mem_ack_i) begin
                        r_req <= 1'b0;
                        if (mem_err_i) begin
                            r_state     <= ERR1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= HRESP_ERROR;
                        end else begin
                            r_state     <= RESP;
                            r_hreadyout <= 1'b1;
                            r_hresp     <= HRESP_OKAY;
                            if (!r_we) begin
                                r_hrdata <= mem_q_i;
                            end
                        end
                    end
                end
                ERR1: begin
                    r_state     <= ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_ERROR;
                end
                default: begin
                    r_state     <= IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_OKAY;
                    r_req       <= 1'b0;
                end
            endcase
        end
    end

    assign HREADYOUT  = r_hreadyout;
    assign HRESP      = r_hresp;
    assign HRDATA     = r_hrdata;
    assign mem_req_o  = r_req;
    assign mem_we_o   = r_we;
    assign mem_adr_o  = r_adr;
    assign mem_be_o   = r_be;
    assign mem_lock_o = r_lock;
    // The master holds HWDATA for the whole data phase, so no register is needed.
    assign mem_d_o    = HWDATA;

endmodule
